dual_port_sram_param: RTL and testbench

//  Parametrised true dual-port synchronous SRAM: next generation of the 16-bit dual-port SRAM.

---
 rtl/dual_port_sram_param.sv | 174 +++++++++++++++++
 tb/tb_dual_port_sram_param.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_sram_param.sv
// dual_port_sram_param: true dual-port synchronous SRAM with byte enables,
// read-valid strobes, post-reset clear sweep and deterministic collisions.
// Latency: read data/valid 1 cycle after request (2 with DPSRAM_OUTPUT_REG_EN).
// Backpressure: none; requests are ignored while the clear sweep runs (Init_Done=0).
//
// Optional feature macro: DPSRAM_OUTPUT_REG_EN adds an output register stage
// on Data_Out and Read_Valid of both ports.
//
// Ports:
//   Clk_In, Reset_In (sync, active-low)
//   Port_{A,B}_Data_In / _Address_In / _Byte_Enable / _Write_Enable / _Read_Enable
//   Port_{A,B}_Data_Out / _Read_Valid
//   Init_Done      : clear sweep finished, requests accepted
//   Collision_Flag : one-cycle strobe, both ports wrote the same address
module dual_port_sram_param #(
  parameter int unsigned                DATA_WIDTH = 16,
  parameter int unsigned                ADDR_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0]      INIT_VALUE = '0
) (
  input  logic                    Clk_In,
  input  logic                    Reset_In,
  input  logic [DATA_WIDTH-1:0]   Port_A_Data_In,
  input  logic [ADDR_WIDTH-1:0]   Port_A_Address_In,
  input  logic [DATA_WIDTH/8-1:0] Port_A_Byte_Enable,
  input  logic                    Port_A_Write_Enable,
  input  logic                    Port_A_Read_Enable,
  output logic [DATA_WIDTH-1:0]   Port_A_Data_Out,
  output logic                    Port_A_Read_Valid,
  input  logic [DATA_WIDTH-1:0]   Port_B_Data_In,
  input  logic [ADDR_WIDTH-1:0]   Port_B_Address_In,
  input  logic [DATA_WIDTH/8-1:0] Port_B_Byte_Enable,
  input  logic                    Port_B_Write_Enable,
  input  logic                    Port_B_Read_Enable,
  output logic [DATA_WIDTH-1:0]   Port_B_Data_Out,
  output logic                    Port_B_Read_Valid,
  output logic                    Init_Done,
  output logic                    Collision_Flag
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    init_done_q;
  logic                    coll_q, coll_d;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic [DATA_WIDTH-1:0]   a_dat_q, b_dat_q;
  logic                    a_vld_q, b_vld_q;

  logic                    run;
  logic                    same_addr;
  logic [NB-1:0]           a_lane_wr;
  logic [NB-1:0]           b_lane_req;
  logic [NB-1:0]           b_lane_wr;

  // ---------------------------------------------------------------------------
  // Sweep/run FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + ADDR_WIDTH'(1);
      if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge Clk_In) begin
    if (!Reset_In) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= (state_d == ST_RUN);
    end
  end

  assign run = (state_q == ST_RUN);

  // ---------------------------------------------------------------------------
  // Write lane decode. On a same-address double write, lanes enabled by both
  // ports take A's data; lanes only B enabled still take B's data.
  // ---------------------------------------------------------------------------
  always_comb begin
    same_addr  = (Port_A_Address_In == Port_B_Address_In);
    a_lane_wr  = {NB{run & Port_A_Write_Enable}} & Port_A_Byte_Enable;
    b_lane_req = {NB{run & Port_B_Write_Enable}} & Port_B_Byte_Enable;
    b_lane_wr  = same_addr ? (b_lane_req & ~a_lane_wr) : b_lane_req;
    coll_d     = same_addr & (|a_lane_wr) & (|b_lane_req);
  end

  // Storage is not reset; the clear sweep provides the defined contents.
  always_ff @(posedge Clk_In) begin
    if (Reset_In && (state_q == ST_INIT)) begin
      mem_q[cnt_q] <= INIT_VALUE;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (a_lane_wr[i]) begin
          mem_q[Port_A_Address_In][8*i +: 8] <= Port_A_Data_In[8*i +: 8];
        end
        if (b_lane_wr[i]) begin
          mem_q[Port_B_Address_In][8*i +: 8] <= Port_B_Data_In[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read stage: the array read sees pre-edge contents, giving read-first
  // behaviour against writes from either port in the same cycle.
  // Data holds its last value when no read is accepted.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk_In) begin
    if (!Reset_In) begin
      a_dat_q <= '0;
      b_dat_q <= '0;
      a_vld_q <= 1'b0;
      b_vld_q <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      a_vld_q <= run & Port_A_Read_Enable;
      b_vld_q <= run & Port_B_Read_Enable;
      coll_q  <= coll_d;
      if (run && Port_A_Read_Enable) begin
        a_dat_q <= mem_q[Port_A_Address_In];
      end
      if (run && Port_B_Read_Enable) begin
        b_dat_q <= mem_q[Port_B_Address_In];
      end
    end
  end

`ifdef DPSRAM_OUTPUT_REG_EN
  logic [DATA_WIDTH-1:0] a_dat2_q, b_dat2_q;
  logic                  a_vld2_q, b_vld2_q;

  always_ff @(posedge Clk_In) begin
    if (!Reset_In) begin
      a_dat2_q <= '0;
      b_dat2_q <= '0;
      a_vld2_q <= 1'b0;
      b_vld2_q <= 1'b0;
    end else begin
      a_dat2_q <= a_dat_q;
      b_dat2_q <= b_dat_q;
      a_vld2_q <= a_vld_q;
      b_vld2_q <= b_vld_q;
    end
  end

  assign Port_A_Data_Out   = a_dat2_q;
  assign Port_B_Data_Out   = b_dat2_q;
  assign Port_A_Read_Valid = a_vld2_q;
  assign Port_B_Read_Valid = b_vld2_q;
`else
  assign Port_A_Data_Out   = a_dat_q;
  assign Port_B_Data_Out   = b_dat_q;
  assign Port_A_Read_Valid = a_vld_q;
  assign Port_B_Read_Valid = b_vld_q;
`endif

  assign Init_Done      = init_done_q;
  assign Collision_Flag = coll_q;

endmodule

// File: tb/tb_dual_port_sram_param.sv
// tb_dual_port_sram_param: directed test of dual_port_sram_param.
// Latency: bench follows 1-cycle reads, or 2 cycles with DPSRAM_OUTPUT_REG_EN.
// Backpressure: n/a; requests are held off by the bench until Init_Done.
module tb_dual_port_sram_param;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;
  localparam logic [DW-1:0] INITV = 16'h5A5A;
`ifdef DPSRAM_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          Clk_In = 1'b0;
  logic          Reset_In;
  logic [DW-1:0] Port_A_Data_In, Port_B_Data_In;
  logic [AW-1:0] Port_A_Address_In, Port_B_Address_In;
  logic [NB-1:0] Port_A_Byte_Enable, Port_B_Byte_Enable;
  logic          Port_A_Write_Enable, Port_B_Write_Enable;
  logic          Port_A_Read_Enable, Port_B_Read_Enable;
  logic [DW-1:0] Port_A_Data_Out, Port_B_Data_Out;
  logic          Port_A_Read_Valid, Port_B_Read_Valid;
  logic          Init_Done, Collision_Flag;

  int checks = 0;
  int errors = 0;

  dual_port_sram_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_VALUE(INITV)
  ) dut (
    .Clk_In(Clk_In), .Reset_In(Reset_In),
    .Port_A_Data_In(Port_A_Data_In), .Port_A_Address_In(Port_A_Address_In),
    .Port_A_Byte_Enable(Port_A_Byte_Enable), .Port_A_Write_Enable(Port_A_Write_Enable),
    .Port_A_Read_Enable(Port_A_Read_Enable), .Port_A_Data_Out(Port_A_Data_Out),
    .Port_A_Read_Valid(Port_A_Read_Valid),
    .Port_B_Data_In(Port_B_Data_In), .Port_B_Address_In(Port_B_Address_In),
    .Port_B_Byte_Enable(Port_B_Byte_Enable), .Port_B_Write_Enable(Port_B_Write_Enable),
    .Port_B_Read_Enable(Port_B_Read_Enable), .Port_B_Data_Out(Port_B_Data_Out),
    .Port_B_Read_Valid(Port_B_Read_Valid),
    .Init_Done(Init_Done), .Collision_Flag(Collision_Flag)
  );

  always #5 Clk_In = ~Clk_In;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk_In);
    #1;
  endtask

  task automatic idle_ports;
    Port_A_Write_Enable = 1'b0; Port_B_Write_Enable = 1'b0;
    Port_A_Read_Enable  = 1'b0; Port_B_Read_Enable  = 1'b0;
    Port_A_Byte_Enable  = '0;   Port_B_Byte_Enable  = '0;
  endtask

  // Issue reads on the selected ports, then wait until the data is visible.
  task automatic read_ab(input logic [AW-1:0] aa, input logic ra,
                         input logic [AW-1:0] ba, input logic rb);
    Port_A_Address_In = aa; Port_A_Read_Enable = ra;
    Port_B_Address_In = ba; Port_B_Read_Enable = rb;
    tick;
    idle_ports;
    repeat (LAT - 1) tick;
  endtask

  task automatic write_a(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    Port_A_Address_In = a; Port_A_Data_In = d; Port_A_Byte_Enable = be;
    Port_A_Write_Enable = 1'b1;
    tick;
    idle_ports;
  endtask

  task automatic sweep_and_count(input string tag);
    int  n;
    logic vld_seen;
    n = 0;
    vld_seen = 1'b0;
    Port_A_Address_In = 8'h10;
    Port_A_Read_Enable = 1'b1;
    Reset_In = 1'b1;
    while (!Init_Done && n < 2 * DEPTH) begin
      tick;
      n++;
      if (Port_A_Read_Valid) vld_seen = 1'b1;
    end
    idle_ports;
    check({tag, "_init_cycles"}, n, DEPTH);
    check({tag, "_no_vld_in_init"}, {31'b0, vld_seen}, 32'd0);
  endtask

  initial begin
    Reset_In = 1'b0;
    Port_A_Data_In = '0; Port_B_Data_In = '0;
    Port_A_Address_In = '0; Port_B_Address_In = '0;
    idle_ports;

    // Reset state
    tick; tick;
    check("rst_a_dat", Port_A_Data_Out, 16'h0000);
    check("rst_b_dat", Port_B_Data_Out, 16'h0000);
    check("rst_a_vld", {31'b0, Port_A_Read_Valid}, 32'd0);
    check("rst_b_vld", {31'b0, Port_B_Read_Valid}, 32'd0);
    check("rst_init_done", {31'b0, Init_Done}, 32'd0);
    check("rst_coll", {31'b0, Collision_Flag}, 32'd0);

    // 1. Sweep timing, then every word holds INIT_VALUE
    sweep_and_count("sweep1");
    for (int i = 0; i < DEPTH; i++) begin
      read_ab(AW'(i), 1'b1, AW'(DEPTH - 1 - i), 1'b1);
      check("sweep_a_dat", Port_A_Data_Out, INITV);
      check("sweep_b_dat", Port_B_Data_Out, INITV);
      check("sweep_a_vld", {31'b0, Port_A_Read_Valid}, 32'd1);
      check("sweep_b_vld", {31'b0, Port_B_Read_Valid}, 32'd1);
    end

    // 2. A writes, B reads next cycle; outputs then hold through an idle cycle
    write_a(8'h10, 16'hBEEF, 2'b11);
    read_ab(8'h00, 1'b0, 8'h10, 1'b1);
    check("t2_b_dat", Port_B_Data_Out, 16'hBEEF);
    check("t2_b_vld", {31'b0, Port_B_Read_Valid}, 32'd1);
    check("t2_a_vld_idle", {31'b0, Port_A_Read_Valid}, 32'd0);
    tick;
    check("t2_b_vld_drop", {31'b0, Port_B_Read_Valid}, 32'd0);
    check("t2_b_dat_hold", Port_B_Data_Out, 16'hBEEF);

    // 3. Partial byte write; zero byte enable writes nothing
    write_a(8'h20, 16'hFFFF, 2'b11);
    write_a(8'h20, 16'h1234, 2'b01);
    read_ab(8'h20, 1'b1, 8'h00, 1'b0);
    check("t3_lane0", Port_A_Data_Out, 16'hFF34);
    write_a(8'h20, 16'h0000, 2'b00);
    read_ab(8'h20, 1'b1, 8'h00, 1'b0);
    check("t3_be_zero", Port_A_Data_Out, 16'hFF34);
    write_a(8'h20, 16'hAB00, 2'b10);
    read_ab(8'h20, 1'b1, 8'h00, 1'b0);
    check("t3_lane1", Port_A_Data_Out, 16'hAB34);

    // 4. Same-address double write: A wins shared lanes, B keeps its own
    Port_A_Address_In = 8'h30; Port_A_Data_In = 16'hAAAA; Port_A_Byte_Enable = 2'b01;
    Port_A_Write_Enable = 1'b1;
    Port_B_Address_In = 8'h30; Port_B_Data_In = 16'h5555; Port_B_Byte_Enable = 2'b11;
    Port_B_Write_Enable = 1'b1;
    tick;
    idle_ports;
    check("t4_coll_pulse", {31'b0, Collision_Flag}, 32'd1);
    tick;
    check("t4_coll_drop", {31'b0, Collision_Flag}, 32'd0);
    read_ab(8'h30, 1'b1, 8'h30, 1'b1);
    check("t4_mem_a", Port_A_Data_Out, 16'h55AA);
    check("t4_mem_b", Port_B_Data_Out, 16'h55AA);

    // Different-address writes in one cycle: no collision, both land
    Port_A_Address_In = 8'h60; Port_A_Data_In = 16'h6060; Port_A_Byte_Enable = 2'b11;
    Port_A_Write_Enable = 1'b1;
    Port_B_Address_In = 8'h61; Port_B_Data_In = 16'h6161; Port_B_Byte_Enable = 2'b11;
    Port_B_Write_Enable = 1'b1;
    tick;
    idle_ports;
    check("diff_addr_no_coll", {31'b0, Collision_Flag}, 32'd0);
    read_ab(8'h61, 1'b1, 8'h60, 1'b1);
    check("diff_addr_a", Port_A_Data_Out, 16'h6161);
    check("diff_addr_b", Port_B_Data_Out, 16'h6060);

    // 5. A writes while B reads same address: B sees old data first
    write_a(8'h40, 16'h0001, 2'b11);
    Port_A_Address_In = 8'h40; Port_A_Data_In = 16'h0002; Port_A_Byte_Enable = 2'b11;
    Port_A_Write_Enable = 1'b1;
    Port_B_Address_In = 8'h40; Port_B_Read_Enable = 1'b1;
    tick;
    idle_ports;
    repeat (LAT - 1) tick;
    check("t5_b_old", Port_B_Data_Out, 16'h0001);
    read_ab(8'h00, 1'b0, 8'h40, 1'b1);
    check("t5_b_new", Port_B_Data_Out, 16'h0002);

    // Reverse direction: B writes while A reads (location holds INIT_VALUE)
    Port_B_Address_In = 8'h41; Port_B_Data_In = 16'h0003; Port_B_Byte_Enable = 2'b11;
    Port_B_Write_Enable = 1'b1;
    Port_A_Address_In = 8'h41; Port_A_Read_Enable = 1'b1;
    tick;
    idle_ports;
    repeat (LAT - 1) tick;
    check("rev_a_old", Port_A_Data_Out, INITV);
    read_ab(8'h41, 1'b1, 8'h00, 1'b0);
    check("rev_a_new", Port_A_Data_Out, 16'h0003);

    // Same-port read+write: read-first
    write_a(8'h50, 16'h1111, 2'b11);
    Port_A_Address_In = 8'h50; Port_A_Data_In = 16'h2222; Port_A_Byte_Enable = 2'b11;
    Port_A_Write_Enable = 1'b1; Port_A_Read_Enable = 1'b1;
    tick;
    idle_ports;
    repeat (LAT - 1) tick;
    check("rw_same_port_old", Port_A_Data_Out, 16'h1111);
    read_ab(8'h50, 1'b1, 8'h00, 1'b0);
    check("rw_same_port_new", Port_A_Data_Out, 16'h2222);

    // 6. Reset mid-sweep restarts it from address 0
    Reset_In = 1'b0;
    tick;
    Reset_In = 1'b1;
    repeat (DEPTH / 2) tick;
    check("t6_mid_not_done", {31'b0, Init_Done}, 32'd0);
    Reset_In = 1'b0;
    Port_A_Address_In = 8'h40; Port_A_Read_Enable = 1'b1;
    tick; tick;
    check("t6_rst_a_dat", Port_A_Data_Out, 16'h0000);
    check("t6_rst_b_dat", Port_B_Data_Out, 16'h0000);
    check("t6_rst_a_vld", {31'b0, Port_A_Read_Valid}, 32'd0);
    check("t6_rst_b_vld", {31'b0, Port_B_Read_Valid}, 32'd0);
    check("t6_rst_done", {31'b0, Init_Done}, 32'd0);
    check("t6_rst_coll", {31'b0, Collision_Flag}, 32'd0);
    idle_ports;
    sweep_and_count("sweep2");
    read_ab(8'h10, 1'b1, 8'hFF, 1'b1);
    check("t6_cleared_a", Port_A_Data_Out, INITV);
    check("t6_cleared_b", Port_B_Data_Out, INITV);
    read_ab(8'h00, 1'b1, 8'h30, 1'b1);
    check("t6_cleared_a0", Port_A_Data_Out, INITV);
    check("t6_cleared_b30", Port_B_Data_Out, INITV);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
